// File: rtl/axi_pkg.sv
// Shared AXI constants and the write-engine state encoding.
// Imported by the AXI bridges in the dsel path.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] SIZE_WORD   = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } wr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port: dout updates on the pop edge
// and holds the popped entry until the next pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            dout   <= mem[rd_ptr];
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/axiw2ram.sv
// AXI write slave: queues AW requests, streams W beats as word writes to a
// local RAM port and returns one B response per burst.
module axiw2ram
   import axi_pkg::*;
#(
   parameter int AXI_AWIDTH  = 32,
   parameter int AXI_DWIDTH  = 32,
   parameter int AXI_IDWIDTH = 3,
   parameter int AXI_LWIDTH  = 8,
   parameter int AXI_SIZE    = 3,
   parameter int AXI_STRB    = 4,
   parameter int LOC_AWIDTH  = 32,
   parameter int LOC_DWIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,

   input  logic [AXI_IDWIDTH-1:0] axi_aw_id,
   input  logic [AXI_AWIDTH-1:0]  axi_aw_addr,
   input  logic [AXI_LWIDTH-1:0]  axi_aw_len,
   input  logic [AXI_SIZE-1:0]    axi_aw_size,
   input  logic                   axi_aw_valid,
   output logic                   axi_aw_ready,

   input  logic [AXI_DWIDTH-1:0]  axi_w_data,
   input  logic [AXI_STRB-1:0]    axi_w_strb,
   input  logic                   axi_w_last,
   input  logic                   axi_w_valid,
   output logic                   axi_w_ready,

   output logic [AXI_IDWIDTH-1:0] axi_b_id,
   output logic [1:0]             axi_b_resp,
   output logic                   axi_b_valid,
   input  logic                   axi_b_ready,

   output logic                   ram_wr_en,
   output logic [LOC_AWIDTH-1:0]  ram_wr_addr,
   output logic [LOC_DWIDTH-1:0]  ram_wr_data,
   output logic [AXI_STRB-1:0]    ram_wr_strb,

   output wr_state_e              dbg_state
);

   localparam int FW = AXI_IDWIDTH + AXI_AWIDTH + AXI_LWIDTH + AXI_SIZE;
   localparam int BW = AXI_AWIDTH - 2;

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // valid never waits on ready; once raised it holds with stable payload
   // until the transfer; ready may be asserted independently of valid.

   wr_state_e              state;
   wr_state_e              state_nxt;

   logic [FW-1:0]          fifo_din;
   logic [FW-1:0]          fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic                   aw_push;

   logic [AXI_IDWIDTH-1:0] f_id;
   logic [AXI_AWIDTH-1:0]  f_addr;
   logic [AXI_LWIDTH-1:0]  f_len;
   logic [AXI_SIZE-1:0]    f_size;
   logic                   unused_addr_lsbs;

   logic [AXI_IDWIDTH-1:0] id_q;
   logic [BW-1:0]          base_q;
   logic [AXI_LWIDTH-1:0]  len_q;
   logic [AXI_LWIDTH-1:0]  beat_cnt;
   logic                   err_q;

   logic                   w_hs;
   logic                   last_beat;

   // AW queue
   assign axi_aw_ready = !fifo_full;
   assign aw_push      = axi_aw_valid && axi_aw_ready;
   assign fifo_din     = {axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size};

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (4)
   ) awfifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (aw_push),
      .din   (fifo_din),
      .full  (fifo_full),
      .rd_en (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   assign {f_id, f_addr, f_len, f_size} = fifo_dout;
   // Byte offset within a word is irrelevant to a word-addressed RAM.
   assign unused_addr_lsbs = ^f_addr[1:0];

   // Burst state machine
   assign axi_w_ready = (state == ST_DATA);
   assign axi_b_valid = (state == ST_RESP);
   assign w_hs        = axi_w_valid && axi_w_ready;
   assign last_beat   = (beat_cnt == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_hs && last_beat) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (axi_b_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Burst context; the popped entry is valid on dout during LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q     <= '0;
         base_q   <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == ST_LOAD) begin
            id_q     <= f_id;
            base_q   <= f_addr[AXI_AWIDTH-1:2];
            len_q    <= f_len;
            beat_cnt <= '0;
            err_q    <= (f_size != AXI_SIZE'(SIZE_WORD));
         end else if (w_hs) begin
            beat_cnt <= beat_cnt + AXI_LWIDTH'(1);
            // Sticky: a misplaced or missing w_last flags the whole burst.
            if (axi_w_last != last_beat) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign axi_b_id   = axi_b_valid ? id_q : '0;
   assign axi_b_resp = (axi_b_valid && err_q) ? RESP_SLVERR : RESP_OKAY;

   // RAM port: zero-strobe beats are consumed without a write.
   assign ram_wr_en   = w_hs && (|axi_w_strb);
   assign ram_wr_addr = LOC_AWIDTH'(base_q) + LOC_AWIDTH'(beat_cnt);
   assign ram_wr_data = axi_w_data;
   assign ram_wr_strb = axi_w_strb;

   assign dbg_state = state;

endmodule

// File: tb/tb_axiw2ram.sv
// Directed bench for axiw2ram: single beats, bursts, strobes, protocol errors,
// AW queue backpressure and reset in the middle of a burst.
module tb_axiw2ram;
   import axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [2:0]  axi_aw_id = '0;
   logic [31:0] axi_aw_addr = '0;
   logic [7:0]  axi_aw_len = '0;
   logic [2:0]  axi_aw_size = '0;
   logic        axi_aw_valid = 1'b0;
   logic        axi_aw_ready;
   logic [31:0] axi_w_data = '0;
   logic [3:0]  axi_w_strb = '0;
   logic        axi_w_last = 1'b0;
   logic        axi_w_valid = 1'b0;
   logic        axi_w_ready;
   logic [2:0]  axi_b_id;
   logic [1:0]  axi_b_resp;
   logic        axi_b_valid;
   logic        axi_b_ready = 1'b0;
   logic        ram_wr_en;
   logic [31:0] ram_wr_addr;
   logic [31:0] ram_wr_data;
   logic [3:0]  ram_wr_strb;
   wr_state_e   dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [67:0] exp_q[$];

   axiw2ram dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .axi_aw_id    (axi_aw_id),
      .axi_aw_addr  (axi_aw_addr),
      .axi_aw_len   (axi_aw_len),
      .axi_aw_size  (axi_aw_size),
      .axi_aw_valid (axi_aw_valid),
      .axi_aw_ready (axi_aw_ready),
      .axi_w_data   (axi_w_data),
      .axi_w_strb   (axi_w_strb),
      .axi_w_last   (axi_w_last),
      .axi_w_valid  (axi_w_valid),
      .axi_w_ready  (axi_w_ready),
      .axi_b_id     (axi_b_id),
      .axi_b_resp   (axi_b_resp),
      .axi_b_valid  (axi_b_valid),
      .axi_b_ready  (axi_b_ready),
      .ram_wr_en    (ram_wr_en),
      .ram_wr_addr  (ram_wr_addr),
      .ram_wr_data  (ram_wr_data),
      .ram_wr_strb  (ram_wr_strb),
      .dbg_state    (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      exp_q.push_back({addr, data, strb});
   endtask

   // Drivers: all called on a falling edge and return on a falling edge.
   task automatic send_aw(input logic [2:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
      int n = 0;
      axi_aw_id    = id;
      axi_aw_addr  = addr;
      axi_aw_len   = len;
      axi_aw_size  = size;
      axi_aw_valid = 1'b1;
      while (!axi_aw_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("aw_accept", axi_aw_ready, 1'b1);
      @(negedge clk);
      axi_aw_valid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      logic [67:0] e;
      axi_w_data  = data;
      axi_w_strb  = strb;
      axi_w_last  = last;
      axi_w_valid = 1'b1;
      #1;
      while (!axi_w_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("w_accept", axi_w_ready, 1'b1);
      check("wr_en", ram_wr_en, |strb);
      if (ram_wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", ram_wr_en, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("ram_write", {ram_wr_addr, ram_wr_data, ram_wr_strb}, e);
         end
      end
      @(negedge clk);
      axi_w_valid = 1'b0;
   endtask

   task automatic get_b(input logic [2:0] id, input logic [1:0] resp, input int hold);
      int n = 0;
      while (!axi_b_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("b_valid", axi_b_valid, 1'b1);
      check("b_id", axi_b_id, id);
      check("b_resp", axi_b_resp, resp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("b_hold", {axi_b_valid, axi_b_id, axi_b_resp}, {1'b1, id, resp});
      end
      axi_b_ready = 1'b1;
      @(negedge clk);
      axi_b_ready = 1'b0;
      check("b_drop", axi_b_valid, 1'b0);
   endtask

   initial begin
      int n;

      // Reset
      repeat (2) @(negedge clk);
      check("rst_aw_ready", axi_aw_ready, 1'b1);
      check("rst_w_ready", axi_w_ready, 1'b0);
      check("rst_b", {axi_b_valid, axi_b_id, axi_b_resp}, 6'd0);
      check("rst_wr_en", ram_wr_en, 1'b0);
      check("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // Single beat with latency
      exp_wr(32'h4, 32'hA5A5_A5A5, 4'hF);
      send_aw(3'd1, 32'h10, 8'd0, 3'd2);
      check("w_ready_early", axi_w_ready, 1'b0);
      n = 0;
      while (!axi_w_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("aw_to_w_latency", n, 2);
      send_w(32'hA5A5_A5A5, 4'hF, 1'b1);
      check("b_rise_single", axi_b_valid, 1'b1);
      get_b(3'd1, 2'b00, 0);

      // Four-beat burst
      for (int i = 0; i < 4; i++) exp_wr(32'h40 + i, i + 1, 4'hF);
      send_aw(3'd2, 32'h100, 8'd3, 3'd2);
      for (int i = 0; i < 4; i++) send_w(i + 1, 4'hF, i == 3);
      check("b_rise_burst", axi_b_valid, 1'b1);
      get_b(3'd2, 2'b00, 0);

      // Partial and zero strobes
      exp_wr(32'h40, 32'h1111_1111, 4'h3);
      exp_wr(32'h42, 32'h3333_3333, 4'hC);
      send_aw(3'd3, 32'h100, 8'd2, 3'd2);
      send_w(32'h1111_1111, 4'h3, 1'b0);
      send_w(32'h2222_2222, 4'h0, 1'b0);
      send_w(32'h3333_3333, 4'hC, 1'b1);
      get_b(3'd3, 2'b00, 0);

      // Early w_last: all beats still consumed and written
      for (int i = 0; i < 3; i++) exp_wr(32'h80 + i, 32'hE000_0000 + i, 4'hF);
      send_aw(3'd4, 32'h200, 8'd2, 3'd2);
      for (int i = 0; i < 3; i++) send_w(32'hE000_0000 + i, 4'hF, i == 1);
      get_b(3'd4, 2'b10, 0);

      // Unsupported size
      exp_wr(32'h8, 32'hCAFE_0001, 4'hF);
      send_aw(3'd5, 32'h20, 8'd0, 3'd1);
      send_w(32'hCAFE_0001, 4'hF, 1'b1);
      get_b(3'd5, 2'b10, 0);

      // Top of the AXI address space, zero-extended word address
      exp_wr(32'h3FFF_FFFF, 32'h0000_00AA, 4'hF);
      exp_wr(32'h4000_0000, 32'h0000_00BB, 4'hF);
      send_aw(3'd6, 32'hFFFF_FFFC, 8'd1, 3'd2);
      send_w(32'h0000_00AA, 4'hF, 1'b0);
      send_w(32'h0000_00BB, 4'hF, 1'b1);
      get_b(3'd6, 2'b00, 0);

      // AW queue fills while the engine holds a burst
      send_aw(3'd0, 32'h300, 8'd1, 3'd2);
      n = 0;
      while (!axi_w_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 1; k < 5; k++) send_aw(3'(k), 32'h300 + k * 32'h100, 8'd0, 3'd2);
      check("aw_full", axi_aw_ready, 1'b0);
      exp_wr(32'hC0, 32'hB000_0000, 4'hF);
      exp_wr(32'hC1, 32'hB000_0001, 4'hF);
      send_w(32'hB000_0000, 4'hF, 1'b0);
      send_w(32'hB000_0001, 4'hF, 1'b1);
      check("aw_full_resp", axi_aw_ready, 1'b0);
      get_b(3'd0, 2'b00, 3);
      for (int k = 1; k < 5; k++) begin
         exp_wr(32'hC0 + k * 32'h40, 32'hB000_0000 + k, 4'hF);
         send_w(32'hB000_0000 + k, 4'hF, 1'b1);
         get_b(3'(k), 2'b00, 1);
      end
      check("aw_drained", axi_aw_ready, 1'b1);

      // Reset in the middle of a burst
      exp_wr(32'h200, 32'hD000_0000, 4'hF);
      exp_wr(32'h201, 32'hD000_0001, 4'hF);
      send_aw(3'd7, 32'h800, 8'd3, 3'd2);
      send_w(32'hD000_0000, 4'hF, 1'b0);
      send_w(32'hD000_0001, 4'hF, 1'b0);
      axi_w_data  = 32'hD000_0002;
      axi_w_strb  = 4'hF;
      axi_w_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_w_ready", axi_w_ready, 1'b0);
      check("mid_rst_b_valid", axi_b_valid, 1'b0);
      check("mid_rst_aw_ready", axi_aw_ready, 1'b1);
      check("mid_rst_wr_en", ram_wr_en, 1'b0);
      @(negedge clk);
      axi_w_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_state", dbg_state, ST_IDLE);
      exp_wr(32'h240, 32'hF000_0000, 4'hF);
      exp_wr(32'h241, 32'hF000_0001, 4'h5);
      send_aw(3'd2, 32'h900, 8'd1, 3'd2);
      send_w(32'hF000_0000, 4'hF, 1'b0);
      send_w(32'hF000_0001, 4'h5, 1'b1);
      get_b(3'd2, 2'b00, 0);
      check("exp_q_empty", exp_q.size(), 0);

      // Report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
